// File: rtl/jcpu_pkg.sv
// ---------------------------------------------------------------------------
// jcpu_pkg
// Shared constants and types for the instruction sequencer: opcode and ALU
// operation encodings, register index width, sequencer phase encoding and
// the control-word bundle produced by the step decoder.
// ---------------------------------------------------------------------------
package jcpu_pkg;

   localparam int REG_IDX_W = 2;
   localparam int NUM_REGS  = 4;

   // Non-ALU opcodes, taken from ir[1:3] when ir[0] = 0.
   typedef enum logic [2:0] {
      OP_LD   = 3'b000,
      OP_ST   = 3'b001,
      OP_DATA = 3'b010,
      OP_JMPR = 3'b011,
      OP_JMP  = 3'b100,
      OP_JCAF = 3'b101,
      OP_CLF  = 3'b110,
      OP_IO   = 3'b111
   } opcode_e;

   // ALU operations, taken from ir[1:3] when ir[0] = 1.
   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SHR = 3'b001,
      ALU_SHL = 3'b010,
      ALU_NOT = 3'b011,
      ALU_AND = 3'b100,
      ALU_OR  = 3'b101,
      ALU_XOR = 3'b110,
      ALU_CMP = 3'b111
   } alu_op_e;

   typedef enum logic {
      PH_EN  = 1'b0,   // enable only
      PH_SET = 1'b1    // enable + set strobe
   } phase_e;

   // Raw decode of one step, before reset / phase qualification.
   typedef struct packed {
      logic            en_bus1;
      logic            en_iar;
      logic            en_ram;
      logic            en_acc;
      logic [0:NUM_REGS-1] en_reg;
      logic            set_iar;
      logic            set_mar;
      logic            set_acc;
      logic            set_ir;
      logic            set_tmp;
      logic            set_ram;
      logic            set_flags;
      logic [0:NUM_REGS-1] set_reg;
   } ctrl_t;

endpackage

// File: rtl/instr_sequencer_if.sv
// ---------------------------------------------------------------------------
// instr_sequencer_if
// Bundles the sequencer's inputs (step_en, halt, ir, flags) and all of its
// step/control outputs. Modport slave is the sequencer's view, master is the
// view of whatever drives it (datapath or testbench).
// ---------------------------------------------------------------------------
interface instr_sequencer_if;

   logic       step_en;
   logic       halt;
   logic [0:7] ir;
   logic [0:3] flags;

   logic [0:5] bos;
   logic       phase;
   logic       halted;

   logic       en_bus1;
   logic       en_iar;
   logic       en_ram;
   logic       en_acc;
   logic [0:3] en_reg;

   logic       set_iar;
   logic       set_mar;
   logic       set_acc;
   logic       set_ir;
   logic       set_tmp;
   logic       set_ram;
   logic       set_flags;
   logic [0:3] set_reg;
   logic [0:2] alu_op;

   modport slave (
      input  step_en, halt, ir, flags,
      output bos, phase, halted,
      output en_bus1, en_iar, en_ram, en_acc, en_reg,
      output set_iar, set_mar, set_acc, set_ir, set_tmp, set_ram, set_flags,
      output set_reg, alu_op
   );

   modport master (
      output step_en, halt, ir, flags,
      input  bos, phase, halted,
      input  en_bus1, en_iar, en_ram, en_acc, en_reg,
      input  set_iar, set_mar, set_acc, set_ir, set_tmp, set_ram, set_flags,
      input  set_reg, alu_op
   );

endinterface

// File: rtl/instr_sequencer_step_ring.sv
// ---------------------------------------------------------------------------
// step_ring
// Six-step one-hot ring with a two-cycle phase per step and a sticky halt.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   i_step_en   - advance qualifier; state holds when 0
//   i_halt      - halt request, only honoured on the step-6 phase-1 advance
//   o_bos       - one-hot step (o_bos[0] = step 1), all zero when halted
//   o_phase     - 0 = enable phase, 1 = enable+set phase
//   o_halted    - sequencer stopped; only reset leaves this state
// ---------------------------------------------------------------------------
module step_ring
   import jcpu_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       i_step_en,
   input  logic       i_halt,
   output logic [0:5] o_bos,
   output logic       o_phase,
   output logic       o_halted
);

   logic [0:5] r_bos;
   phase_e     r_phase;
   logic       r_halted;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_bos    <= 6'b100000;
         r_phase  <= PH_EN;
         r_halted <= 1'b0;
      end else if (i_step_en && !r_halted) begin
         if (r_phase == PH_EN) begin
            r_phase <= PH_SET;
         end else begin
            r_phase <= PH_EN;
            if (r_bos[5]) begin
               if (i_halt) begin
                  r_bos    <= '0;
                  r_halted <= 1'b1;
               end else begin
                  r_bos <= 6'b100000;
               end
            end else begin
               r_bos <= {1'b0, r_bos[0:4]};   // move one-hot toward step 6
            end
         end
      end
   end

   assign o_bos    = r_bos;
   assign o_phase  = r_phase;
   assign o_halted = r_halted;

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
// Control unit for a simple 8-bit CPU: the step ring supplies the current
// step and phase, and this module decodes (step, ir, flags) into bus enables,
// register set strobes and the ALU operation.
// Ports:
//   clk, reset - clock, synchronous active-high reset
//   bus        - instr_sequencer_if.slave: step_en/halt/ir/flags in;
//                bos/phase/halted, enables, set strobes and alu_op out
// Enables are live in both phases of a step; set strobes fire only in
// phase 1 of an advancing cycle. Everything is forced low during reset.
// ---------------------------------------------------------------------------
module instr_sequencer
   import jcpu_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   instr_sequencer_if.slave   bus
);

   logic [0:5]           w_bos;
   logic                 w_phase;
   logic                 w_halted;
   ctrl_t                w_ctrl;
   logic [REG_IDX_W-1:0] w_ra;
   logic [REG_IDX_W-1:0] w_rb;
   opcode_e              w_op;
   logic                 w_alu_cls;
   logic                 w_live;
   logic                 w_strobe;
   logic [0:2]           w_alu_op;

   step_ring u_step_ring (
      .clk       (clk),
      .reset     (reset),
      .i_step_en (bus.step_en),
      .i_halt    (bus.halt),
      .o_bos     (w_bos),
      .o_phase   (w_phase),
      .o_halted  (w_halted)
   );

   assign w_ra      = bus.ir[4:5];
   assign w_rb      = bus.ir[6:7];
   assign w_op      = opcode_e'(bus.ir[1:3]);
   assign w_alu_cls = bus.ir[0];

   // NOTE: every field gets a default before the decode so no path through
   // the if/case tree leaves a signal unassigned and infers a latch.
   always_comb begin
      w_ctrl = '0;
      if (w_bos[0]) begin
         w_ctrl.en_bus1 = 1'b1;
         w_ctrl.en_iar  = 1'b1;
         w_ctrl.set_mar = 1'b1;
         w_ctrl.set_acc = 1'b1;
      end else if (w_bos[1]) begin
         w_ctrl.en_ram = 1'b1;
         w_ctrl.set_ir = 1'b1;
      end else if (w_bos[2]) begin
         w_ctrl.en_acc  = 1'b1;
         w_ctrl.set_iar = 1'b1;
      end else if (w_alu_cls) begin
         if (w_bos[3]) begin
            w_ctrl.en_reg[w_rb] = 1'b1;
            w_ctrl.set_tmp      = 1'b1;
         end else if (w_bos[4]) begin
            w_ctrl.en_reg[w_ra] = 1'b1;
            w_ctrl.set_acc      = 1'b1;
            w_ctrl.set_flags    = 1'b1;
         end else if (w_bos[5] && (alu_op_e'(bus.ir[1:3]) != ALU_CMP)) begin
            // CMP only updates flags; the result is not written back.
            w_ctrl.en_acc        = 1'b1;
            w_ctrl.set_reg[w_rb] = 1'b1;
         end
      end else begin
         case (w_op)
            OP_LD: begin
               if (w_bos[3]) begin
                  w_ctrl.en_reg[w_ra] = 1'b1;
                  w_ctrl.set_mar      = 1'b1;
               end else if (w_bos[4]) begin
                  w_ctrl.en_ram        = 1'b1;
                  w_ctrl.set_reg[w_rb] = 1'b1;
               end
            end
            OP_ST: begin
               if (w_bos[3]) begin
                  w_ctrl.en_reg[w_ra] = 1'b1;
                  w_ctrl.set_mar      = 1'b1;
               end else if (w_bos[4]) begin
                  w_ctrl.en_reg[w_rb] = 1'b1;
                  w_ctrl.set_ram      = 1'b1;
               end
            end
            OP_DATA: begin
               if (w_bos[3]) begin
                  w_ctrl.en_bus1 = 1'b1;
                  w_ctrl.en_iar  = 1'b1;
                  w_ctrl.set_mar = 1'b1;
                  w_ctrl.set_acc = 1'b1;
               end else if (w_bos[4]) begin
                  w_ctrl.en_ram        = 1'b1;
                  w_ctrl.set_reg[w_rb] = 1'b1;
               end else if (w_bos[5]) begin
                  w_ctrl.en_acc  = 1'b1;
                  w_ctrl.set_iar = 1'b1;
               end
            end
            OP_JMPR: begin
               if (w_bos[3]) begin
                  w_ctrl.en_reg[w_rb] = 1'b1;
                  w_ctrl.set_iar      = 1'b1;
               end
            end
            OP_JMP: begin
               if (w_bos[3]) begin
                  w_ctrl.en_iar  = 1'b1;
                  w_ctrl.set_mar = 1'b1;
               end else if (w_bos[4]) begin
                  w_ctrl.en_ram  = 1'b1;
                  w_ctrl.set_iar = 1'b1;
               end
            end
            OP_JCAF: begin
               // s4/s5 step IAR past the target byte; s6 loads the target
               // only when a selected flag (ir[4:7] = C,A,E,Z mask) is set.
               if (w_bos[3]) begin
                  w_ctrl.en_bus1 = 1'b1;
                  w_ctrl.en_iar  = 1'b1;
                  w_ctrl.set_mar = 1'b1;
                  w_ctrl.set_acc = 1'b1;
               end else if (w_bos[4]) begin
                  w_ctrl.en_acc  = 1'b1;
                  w_ctrl.set_iar = 1'b1;
               end else if (w_bos[5] && |(bus.ir[4:7] & bus.flags)) begin
                  w_ctrl.en_ram  = 1'b1;
                  w_ctrl.set_iar = 1'b1;
               end
            end
            OP_CLF: begin
               if (w_bos[3]) begin
                  w_ctrl.en_bus1   = 1'b1;
                  w_ctrl.set_flags = 1'b1;
               end
            end
            OP_IO: ;
         endcase
      end
   end

   assign w_alu_op = (w_bos[4] && w_alu_cls) ? bus.ir[1:3] : 3'b000;

   // A reset cycle must never strobe, even if the ring is mid-instruction.
   assign w_live   = ~reset;
   assign w_strobe = w_phase & bus.step_en & ~reset;

   assign bus.bos       = w_bos;
   assign bus.phase     = w_phase;
   assign bus.halted    = w_halted;

   assign bus.en_bus1   = w_ctrl.en_bus1 & w_live;
   assign bus.en_iar    = w_ctrl.en_iar  & w_live;
   assign bus.en_ram    = w_ctrl.en_ram  & w_live;
   assign bus.en_acc    = w_ctrl.en_acc  & w_live;
   assign bus.en_reg    = w_ctrl.en_reg  & {NUM_REGS{w_live}};

   assign bus.set_iar   = w_ctrl.set_iar   & w_strobe;
   assign bus.set_mar   = w_ctrl.set_mar   & w_strobe;
   assign bus.set_acc   = w_ctrl.set_acc   & w_strobe;
   assign bus.set_ir    = w_ctrl.set_ir    & w_strobe;
   assign bus.set_tmp   = w_ctrl.set_tmp   & w_strobe;
   assign bus.set_ram   = w_ctrl.set_ram   & w_strobe;
   assign bus.set_flags = w_ctrl.set_flags & w_strobe;
   assign bus.set_reg   = w_ctrl.set_reg   & {NUM_REGS{w_strobe}};

   assign bus.alu_op    = w_live ? w_alu_op : 3'b000;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
// Directed bench for instr_sequencer. Inputs change on the falling edge and
// outputs are sampled 1 time unit later, well away from the rising edge.
// Control outputs are packed into one 22-bit word (see ctrl_vec) and compared
// against hand-built expected words.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

   logic clk;
   logic reset;
   int   errors;
   int   checks;

   instr_sequencer_if bus ();

   instr_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Control word bit positions.
   localparam logic [21:0] EN_BUS1   = 22'h1 << 21;
   localparam logic [21:0] EN_IAR    = 22'h1 << 20;
   localparam logic [21:0] EN_RAM    = 22'h1 << 19;
   localparam logic [21:0] EN_ACC    = 22'h1 << 18;
   localparam logic [21:0] SET_IAR   = 22'h1 << 13;
   localparam logic [21:0] SET_MAR   = 22'h1 << 12;
   localparam logic [21:0] SET_ACC   = 22'h1 << 11;
   localparam logic [21:0] SET_IR    = 22'h1 << 10;
   localparam logic [21:0] SET_TMP   = 22'h1 << 9;
   localparam logic [21:0] SET_RAM   = 22'h1 << 8;
   localparam logic [21:0] SET_FLAGS = 22'h1 << 7;

   // v is written as printed: leftmost bit is register 0.
   function automatic logic [21:0] ereg(input logic [3:0] v);
      return {4'b0, v, 14'b0};
   endfunction

   function automatic logic [21:0] sreg(input logic [3:0] v);
      return {15'b0, v, 3'b0};
   endfunction

   function automatic logic [21:0] aop(input logic [2:0] v);
      return {19'b0, v};
   endfunction

   function automatic logic [21:0] ctrl_vec();
      return {bus.en_bus1, bus.en_iar, bus.en_ram, bus.en_acc, bus.en_reg,
              bus.set_iar, bus.set_mar, bus.set_acc, bus.set_ir, bus.set_tmp,
              bus.set_ram, bus.set_flags, bus.set_reg, bus.alu_op};
   endfunction

   // Expected fetch controls for cycle i (0..5) with step_en held high.
   function automatic logic [21:0] fetch_exp(input int i);
      case (i)
         0:       return EN_BUS1 | EN_IAR;
         1:       return EN_BUS1 | EN_IAR | SET_MAR | SET_ACC;
         2:       return EN_RAM;
         3:       return EN_RAM | SET_IR;
         4:       return EN_ACC;
         default: return EN_ACC | SET_IAR;
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      bus.step_en = 1'b1;
      bus.halt = 1'b0;
      bus.ir = 8'b10000110;
      bus.flags = 4'b0000;
      @(negedge clk);
      #1;
      checks++;
      if (bus.bos !== 6'b100000 || bus.phase !== 1'b0 || bus.halted !== 1'b0) begin
         errors++;
         $display("FAIL reset_state bos=%b phase=%b halted=%b, want 100000/0/0",
                  bus.bos, bus.phase, bus.halted);
      end
      checks++;
      if (ctrl_vec() !== 22'h0) begin
         errors++;
         $display("FAIL reset_ctrl got %b want %b", ctrl_vec(), 22'h0);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Fetch then ADD RA=1 RB=2, starting from step 1 phase 0.
   task automatic test_fetch_alu();
      logic [21:0] exp [12];
      logic [0:5]  eb;
      for (int i = 0; i < 6; i++) exp[i] = fetch_exp(i);
      exp[6]  = ereg(4'b0010);
      exp[7]  = ereg(4'b0010) | SET_TMP;
      exp[8]  = ereg(4'b0100) | aop(3'b000);
      exp[9]  = ereg(4'b0100) | aop(3'b000) | SET_ACC | SET_FLAGS;
      exp[10] = EN_ACC;
      exp[11] = EN_ACC | sreg(4'b0010);
      bus.ir = 8'b10000110;
      for (int i = 0; i < 12; i++) begin
         #1;
         eb = 6'b100000 >> (i / 2);
         checks++;
         if (bus.bos !== eb || bus.phase !== 1'(i % 2)) begin
            errors++;
            $display("FAIL add_step c%0d bos=%b phase=%b want %b/%0d",
                     i, bus.bos, bus.phase, eb, i % 2);
         end
         checks++;
         if (ctrl_vec() !== exp[i]) begin
            errors++;
            $display("FAIL add_ctrl c%0d got %b want %b", i, ctrl_vec(), exp[i]);
         end
         @(negedge clk);
      end
   endtask

   // JCAF with mask C: flag pattern decides whether step 6 loads IAR.
   task automatic test_jcaf(input logic [3:0] flg, input logic taken);
      logic [21:0] exp [12];
      for (int i = 0; i < 6; i++) exp[i] = fetch_exp(i);
      exp[6]  = EN_BUS1 | EN_IAR;
      exp[7]  = EN_BUS1 | EN_IAR | SET_MAR | SET_ACC;
      exp[8]  = EN_ACC;
      exp[9]  = EN_ACC | SET_IAR;
      exp[10] = taken ? EN_RAM : 22'h0;
      exp[11] = taken ? (EN_RAM | SET_IAR) : 22'h0;
      bus.ir = 8'b01011000;
      bus.flags = flg;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks++;
         if (ctrl_vec() !== exp[i]) begin
            errors++;
            $display("FAIL jcaf_f%b c%0d got %b want %b", flg, i, ctrl_vec(), exp[i]);
         end
         @(negedge clk);
      end
      bus.flags = 4'b0000;
   endtask

   // CMP RA=0 RB=1: flags written in step 5, no write-back in step 6.
   task automatic test_cmp();
      logic [21:0] exp [12];
      for (int i = 0; i < 6; i++) exp[i] = fetch_exp(i);
      exp[6]  = ereg(4'b0100);
      exp[7]  = ereg(4'b0100) | SET_TMP;
      exp[8]  = ereg(4'b1000) | aop(3'b111);
      exp[9]  = ereg(4'b1000) | aop(3'b111) | SET_ACC | SET_FLAGS;
      exp[10] = 22'h0;
      exp[11] = 22'h0;
      bus.ir = 8'b11110001;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks++;
         if (ctrl_vec() !== exp[i]) begin
            errors++;
            $display("FAIL cmp_ctrl c%0d got %b want %b", i, ctrl_vec(), exp[i]);
         end
         @(negedge clk);
      end
   endtask

   // LD RA=1 RB=2 with a 3-cycle stall in step 2 phase 1.
   task automatic test_stall();
      logic [21:0] exp [8];
      logic [0:5]  eb;
      exp[0] = EN_ACC;
      exp[1] = EN_ACC | SET_IAR;
      exp[2] = ereg(4'b0100);
      exp[3] = ereg(4'b0100) | SET_MAR;
      exp[4] = EN_RAM;
      exp[5] = EN_RAM | sreg(4'b0010);
      exp[6] = 22'h0;
      exp[7] = 22'h0;
      bus.ir = 8'b00000110;
      repeat (3) @(negedge clk);
      bus.step_en = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (bus.bos !== 6'b010000 || bus.phase !== 1'b1 || ctrl_vec() !== EN_RAM) begin
            errors++;
            $display("FAIL stall_hold k%0d bos=%b phase=%b ctrl=%b want 010000/1/%b",
                     k, bus.bos, bus.phase, ctrl_vec(), EN_RAM);
         end
         @(negedge clk);
      end
      bus.step_en = 1'b1;
      #1;
      checks++;
      if (ctrl_vec() !== (EN_RAM | SET_IR)) begin
         errors++;
         $display("FAIL stall_resume got %b want %b", ctrl_vec(), EN_RAM | SET_IR);
      end
      @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         #1;
         eb = 6'b001000 >> (i / 2);
         checks++;
         if (bus.bos !== eb || ctrl_vec() !== exp[i]) begin
            errors++;
            $display("FAIL ld_tail c%0d bos=%b ctrl=%b want %b/%b",
                     i, bus.bos, ctrl_vec(), eb, exp[i]);
         end
         @(negedge clk);
      end
   endtask

   // IO instruction with halt held high throughout: only the step-6 advance
   // may act on it.
   task automatic test_halt();
      bus.ir = 8'b01110000;
      bus.halt = 1'b1;
      for (int i = 0; i < 12; i++) begin
         #1;
         checks++;
         if (bus.halted !== 1'b0 || ctrl_vec() !== ((i < 6) ? fetch_exp(i) : 22'h0)) begin
            errors++;
            $display("FAIL halt_early c%0d halted=%b ctrl=%b", i, bus.halted, ctrl_vec());
         end
         @(negedge clk);
      end
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (bus.bos !== 6'b000000 || bus.halted !== 1'b1 || ctrl_vec() !== 22'h0) begin
            errors++;
            $display("FAIL halted k%0d bos=%b halted=%b ctrl=%b want 000000/1/0",
                     k, bus.bos, bus.halted, ctrl_vec());
         end
         bus.halt = 1'b0;
         @(negedge clk);
      end
   endtask

   // Leave halt via reset, run ADD to step 4 phase 1, then reset there.
   task automatic test_reset_mid();
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      bus.ir = 8'b10000110;
      repeat (7) @(negedge clk);
      #1;
      checks++;
      if (ctrl_vec() !== (ereg(4'b0010) | SET_TMP)) begin
         errors++;
         $display("FAIL s4p1_pre got %b want %b", ctrl_vec(), ereg(4'b0010) | SET_TMP);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (ctrl_vec() !== 22'h0 || bus.bos !== 6'b000100) begin
         errors++;
         $display("FAIL reset_mid_cycle ctrl=%b bos=%b want 0/000100", ctrl_vec(), bus.bos);
      end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if (bus.bos !== 6'b100000 || bus.phase !== 1'b0 || bus.halted !== 1'b0 ||
          ctrl_vec() !== (EN_BUS1 | EN_IAR)) begin
         errors++;
         $display("FAIL after_reset bos=%b phase=%b halted=%b ctrl=%b want 100000/0/0/%b",
                  bus.bos, bus.phase, bus.halted, ctrl_vec(), EN_BUS1 | EN_IAR);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_fetch_alu();
      test_jcaf(4'b1000, 1'b1);
      test_jcaf(4'b0100, 1'b0);
      test_cmp();
      test_stall();
      test_halt();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
